// File: rtl/iobuf_bank_if.sv
// Control/status bundle between a host and the iobuf_bank pin-buffer controller.
// There is no valid/ready handshake: every signal is a level, sampled on each rising clock edge.
interface iobuf_bank_if #(
    parameter int CHANNELS     = 5,
    parameter int FILTER_WIDTH = 4
);
    logic [2*CHANNELS-1:0]   mode;
    logic [CHANNELS-1:0]     dout;
    logic [CHANNELS-1:0]     din;
    logic [FILTER_WIDTH-1:0] filter_limit;
    logic [CHANNELS-1:0]     contention_clear;
    logic [CHANNELS-1:0]     contention;
    logic                    contention_any;
    logic [CHANNELS-1:0]     bufdir;
    logic [CHANNELS-1:0]     bufod;

    modport master (
        output mode, dout, filter_limit, contention_clear,
        input  din, contention, contention_any, bufdir, bufod
    );

    modport slave (
        input  mode, dout, filter_limit, contention_clear,
        output din, contention, contention_any, bufdir, bufod
    );
endinterface

// File: rtl/iobuf_bank.sv
// Bank of bidirectional pin channels behind 74LVC buffers: break-before-make direction
// turnaround, input synchronisers and a filtered, sticky drive-contention detector.
module iobuf_bank #(
    parameter int CHANNELS     = 5,
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_WIDTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    iobuf_bank_if.slave             bus,
    inout  wire  [CHANNELS-1:0]     bufio_io,
    output logic [2*CHANNELS-1:0]   state_dbg_o
);
    localparam logic [1:0] S_IN       = 2'd0;
    localparam logic [1:0] S_TURN_OUT = 2'd1;
    localparam logic [1:0] S_OUT      = 2'd2;
    localparam logic [1:0] S_TURN_IN  = 2'd3;
    localparam logic [FILTER_WIDTH-1:0] CNT_ONE = {{(FILTER_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]              state_q [CHANNELS];
    logic [1:0]              state_d [CHANNELS];
    logic [FILTER_WIDTH-1:0] cnt_q   [CHANNELS];
    logic [FILTER_WIDTH-1:0] cnt_d   [CHANNELS];
    logic [FILTER_WIDTH-1:0] cnt_inc [CHANNELS];
    logic [CHANNELS-1:0]     sync_q    [SYNC_STAGES];
    logic [CHANNELS-1:0]     en_dly_q  [SYNC_STAGES];
    logic [CHANNELS-1:0]     val_dly_q [SYNC_STAGES];

    logic [CHANNELS-1:0] want_drive;
    logic [CHANNELS-1:0] drive_en;
    logic [CHANNELS-1:0] dir;
    logic [CHANNELS-1:0] drive_val_q, drive_val_d;
    logic [CHANNELS-1:0] bufod_q, bufod_d;
    logic [CHANNELS-1:0] cont_q, cont_d;
    logic [CHANNELS-1:0] mismatch;

    always_comb begin
        state_dbg_o = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            want_drive[c]  = (bus.mode[2*c +: 2] == 2'b01) ||
                             ((bus.mode[2*c +: 2] == 2'b10) && !bus.dout[c]);
            drive_en[c]    = (state_q[c] == S_OUT);
            dir[c]         = (state_q[c] != S_IN);
            drive_val_d[c] = (bus.mode[2*c +: 2] == 2'b01) && bus.dout[c];
            bufod_d[c]     = (bus.mode[2*c +: 2] == 2'b10);
            state_dbg_o[2*c +: 2] = state_q[c];

            // TURN_IN always runs to completion so bufdir never drops with the drive.
            state_d[c] = state_q[c];
            case (state_q[c])
                S_IN:       if (want_drive[c]) state_d[c] = S_TURN_OUT;
                S_TURN_OUT: state_d[c] = want_drive[c] ? S_OUT : S_IN;
                S_OUT:      if (!want_drive[c]) state_d[c] = S_TURN_IN;
                default:    state_d[c] = S_IN;
            endcase

            // Compare the synchronised pin only against what was driven in that same cycle.
            mismatch[c] = en_dly_q[SYNC_STAGES-1][c] &&
                          (sync_q[SYNC_STAGES-1][c] != val_dly_q[SYNC_STAGES-1][c]);
            cnt_inc[c]  = (&cnt_q[c]) ? cnt_q[c] : cnt_q[c] + CNT_ONE;
            cnt_d[c]    = mismatch[c] ? cnt_inc[c] : '0;
            cont_d[c]   = (mismatch[c] && (bus.filter_limit != '0) &&
                           (cnt_inc[c] >= bus.filter_limit)) ||
                          (cont_q[c] && !bus.contention_clear[c]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= S_IN;
                cnt_q[c]   <= '0;
            end
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s]    <= '0;
                en_dly_q[s]  <= '0;
                val_dly_q[s] <= '0;
            end
            drive_val_q <= '0;
            bufod_q     <= '0;
            cont_q      <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
            sync_q[0]    <= bufio_io;
            en_dly_q[0]  <= drive_en;
            val_dly_q[0] <= drive_val_q;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s]    <= sync_q[s-1];
                en_dly_q[s]  <= en_dly_q[s-1];
                val_dly_q[s] <= val_dly_q[s-1];
            end
            drive_val_q <= drive_val_d;
            bufod_q     <= bufod_d;
            cont_q      <= cont_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_pin
        assign bufio_io[g] = drive_en[g] ? drive_val_q[g] : 1'bz;
    end

    assign bus.din            = sync_q[SYNC_STAGES-1];
    assign bus.contention     = cont_q;
    assign bus.contention_any = |cont_q;
    assign bus.bufdir         = dir;
    assign bus.bufod          = bufod_q;
endmodule
